// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, WIDTH cycles per add.
// Optional subtract mode (A-B, Co=borrow) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             sub_q;
   logic             sub_in;
   logic             accept;
   logic [1:0]       fa;

   // Returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_in = sub;

   always_ff @(posedge clk) begin
      if (!rst_n)
         sub_q <= 1'b0;
      else if (accept)
         sub_q <= sub;
   end
`else
   assign sub_in = 1'b0;
   assign sub_q  = 1'b0;
`endif

   assign accept = start && (state != RUN);
   assign fa     = full_add(a_sr[0], b_sr[0] ^ sub_q, carry);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? RUN : IDLE;
         RUN:     state_nxt = (cnt == LAST) ? DONE : RUN;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         S     <= '0;
         Co    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            cnt   <= '0;
            carry <= sub_in;
         end else if (state == RUN) begin
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            r_sr  <= {fa[0], r_sr[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa[1];
            cnt   <= cnt + 1'b1;
            if (cnt == LAST) begin
               S  <= {fa[0], r_sr[WIDTH-1:1]};
               Co <= fa[1] ^ sub_q;
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A, B, S;
   logic         Co, busy, done;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .A     (A),
      .B     (B),
      .S     (S),
      .Co    (Co),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One start pulse, then wait (bounded) for done; operands are scrambled after acceptance.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] s, output logic co,
                        output int lat, output int busyc, output logic busy_at_done);
      A = a; B = b; start = 1'b1;
      tick();
      start = 1'b0;
      A = W'($urandom()); B = W'($urandom());
      lat = 0; busyc = 0;
      while (!done && lat < 40) begin
         if (busy) busyc++;
         tick();
         lat++;
      end
      s = S; co = Co; busy_at_done = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      repeat (3) tick();
      checks++; if (S !== '0)     begin errors++; $display("FAIL reset_S: got %h expected 00", S); end
      checks++; if (Co !== 1'b0)  begin errors++; $display("FAIL reset_Co: got %b expected 0", Co); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] s; logic co, bd; int lat, bc;
      do_op(8'h5A, 8'h3C, s, co, lat, bc, bd);
      checks++; if (lat != W)  begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
      checks++; if (bc != W)   begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, W); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_with_done: got %b expected 0", bd); end
      checks++; if (s !== 8'h96) begin errors++; $display("FAIL basic_S: got %h expected 96", s); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_Co: got %b expected 0", co); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", done); end
      checks++; if (S !== 8'h96) begin errors++; $display("FAIL basic_S_hold: got %h expected 96", S); end
   endtask

   task automatic test_carry_clear();
      logic [W-1:0] s; logic co, bd; int lat, bc;
      do_op(8'hFF, 8'h01, s, co, lat, bc, bd);
      checks++; if (lat != W || s !== 8'h00 || co !== 1'b1)
         begin errors++; $display("FAIL carry_ff01: got S=%h Co=%b lat=%0d expected S=00 Co=1 lat=%0d", s, co, lat, W); end
      tick();
      do_op(8'h00, 8'h00, s, co, lat, bc, bd);
      checks++; if (lat != W || s !== 8'h00 || co !== 1'b0)
         begin errors++; $display("FAIL carry_0000: got S=%h Co=%b lat=%0d expected S=00 Co=0 lat=%0d", s, co, lat, W); end
   endtask

   task automatic test_random();
      logic [W-1:0] s, a, b; logic co, bd; int lat, bc; logic [W:0] exp;
      for (int i = 0; i < 12; i++) begin
         a = W'($urandom()); b = W'($urandom());
         exp = ref_add(a, b);
         do_op(a, b, s, co, lat, bc, bd);
         checks++; if (lat != W || s !== exp[W-1:0] || co !== exp[W])
            begin errors++; $display("FAIL random_add %h+%h: got S=%h Co=%b lat=%0d expected S=%h Co=%b", a, b, s, co, lat, exp[W-1:0], exp[W]); end
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa[$], qb[$]; logic [W:0] exp; int n;
      for (int i = 0; i < 6; i++) begin
         qa.push_back(W'($urandom())); qb.push_back(W'($urandom()));
      end
      A = qa[0]; B = qb[0]; start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d: busy got %b expected 1", k, busy); end
         if (k < 5) begin A = qa[k+1]; B = qb[k+1]; end
         else begin start = 1'b0; A = W'($urandom()); B = W'($urandom()); end
         n = 0;
         while (!done && n < 40) begin tick(); n++; end
         exp = ref_add(qa[k], qb[k]);
         checks++; if (n != W || S !== exp[W-1:0] || Co !== exp[W])
            begin errors++; $display("FAIL b2b_op_%0d: got S=%h Co=%b ticks=%0d expected S=%h Co=%b ticks=%0d", k, S, Co, n, exp[W-1:0], exp[W], W); end
      end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy); end
   endtask

   task automatic test_ignore_start();
      int n, extra;
      A = 8'h5A; B = 8'h3C; start = 1'b1;
      tick();
      start = 1'b0; A = '0; B = '0;
      tick(); tick();
      A = 8'h11; B = 8'h22; start = 1'b1;
      tick();
      start = 1'b0;
      n = 3;
      while (!done && n < 40) begin tick(); n++; end
      checks++; if (n != W || S !== 8'h96 || Co !== 1'b0)
         begin errors++; $display("FAIL ignore_result: got S=%h Co=%b ticks=%0d expected S=96 Co=0 ticks=%0d", S, Co, n, W); end
      extra = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (done) extra++; end
      checks++; if (extra != 0) begin errors++; $display("FAIL ignore_extra_done: got %0d pulses expected 0", extra); end
      checks++; if (S !== 8'h96) begin errors++; $display("FAIL ignore_S_hold: got %h expected 96", S); end
   endtask

   task automatic test_reset_midrun();
      logic [W-1:0] s, a, b; logic co, bd; int lat, bc, pulses; logic [W:0] exp;
      A = 8'hC3; B = 8'h7E; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy: got %b expected 1", busy); end
      rst_n = 1'b0;
      tick();
      checks++; if (S !== '0 || Co !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL midrun_reset: got S=%h Co=%b busy=%b done=%b expected 00 0 0 0", S, Co, busy, done); end
      pulses = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (done || busy) pulses++; end
      checks++; if (pulses != 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", pulses); end
      rst_n = 1'b1;
      a = W'($urandom()); b = W'($urandom()); exp = ref_add(a, b);
      do_op(a, b, s, co, lat, bc, bd);
      checks++; if (lat != W || s !== exp[W-1:0] || co !== exp[W])
         begin errors++; $display("FAIL midrun_after: got S=%h Co=%b lat=%0d expected S=%h Co=%b", s, co, lat, exp[W-1:0], exp[W]); end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      logic [W-1:0] s, a, b, d; logic co, bd; int lat, bc;
      sub = 1'b1;
      do_op(8'h10, 8'h20, s, co, lat, bc, bd);
      checks++; if (s !== 8'hF0 || co !== 1'b1) begin errors++; $display("FAIL sub_10_20: got S=%h Co=%b expected F0 1", s, co); end
      do_op(8'h20, 8'h10, s, co, lat, bc, bd);
      checks++; if (s !== 8'h10 || co !== 1'b0) begin errors++; $display("FAIL sub_20_10: got S=%h Co=%b expected 10 0", s, co); end
      for (int i = 0; i < 6; i++) begin
         a = W'($urandom()); b = W'($urandom()); d = a - b;
         do_op(a, b, s, co, lat, bc, bd);
         checks++; if (s !== d || co !== (a < b))
            begin errors++; $display("FAIL sub_random %h-%h: got S=%h Co=%b expected S=%h Co=%b", a, b, s, co, d, (a < b)); end
      end
      sub = 1'b0;
      do_op(8'hF0, 8'h20, s, co, lat, bc, bd);
      checks++; if (s !== 8'h10 || co !== 1'b1) begin errors++; $display("FAIL sub_off_add: got S=%h Co=%b expected 10 1", s, co); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_carry_clear();
      test_random();
      test_back_to_back();
      test_ignore_start();
      test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
